multdiv_sequencer: RTL and testbench

- Iterative multi-cycle multiply/divide unit that owns the HI/LO register pair for the single-cycle processor.
- Takes MULT/MULTU/DIV/DIVU requests from the control unit together with the two register operands.
- Sequences one radix-2 step per cycle.
- Asserts busy so the control unit can stall the pipeline of instructions that read HI/LO.
- Also services direct HI/LO writes (MTHI/MTLO).

---
 rtl/multdiv_pkg.sv | 29 ++
 rtl/multdiv_step.sv | 29 ++
 rtl/multdiv_sequencer.sv | 176 +++++++++++++++++
 tb/tb_multdiv_sequencer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multdiv_pkg.sv
// Shared types for the iterative multiply/divide unit: opcodes, FSM states, default width.
package multdiv_pkg;

  localparam int MD_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_RUN,
    S_FIX,
    S_DONE
  } state_e;

  function automatic logic op_is_div(input op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input op_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/multdiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring subtract-shift for divide.
module multdiv_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [2*WIDTH-1:0] opnd_i,
  input  logic               mbit_i,
  input  logic               is_div_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;

  // Divide: acc = {remainder, dividend/quotient}; the quotient bit shifts in at the bottom.
  // The extra remainder bit keeps the trial subtraction exact; diff[WIDTH] is the borrow.
  always_comb begin
    rem_sh = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
    diff   = rem_sh - {1'b0, opnd_i[WIDTH-1:0]};
    acc_o  = acc_i;
    if (is_div_i) begin
      if (!diff[WIDTH]) acc_o = {diff[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
      else              acc_o = {rem_sh[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
    end else if (mbit_i) begin
      acc_o = acc_i + opnd_i;
    end
  end

endmodule

// File: rtl/multdiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO; one radix-2 step per RUN cycle.
// Optional MULTDIV_EARLY_OUT_EN: multiplies leave RUN once the remaining multiplier bits are zero.
module multdiv_sequencer
  import multdiv_pkg::*;
#(
  parameter  int WIDTH = MD_WIDTH,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [1:0]       hilo_we_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             div_zero_o
);

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, opnd_q, opnd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               negq_q, negq_d, negr_q, negr_d;
  logic               dz_q, dz_d, divz_q, divz_d;

  logic               is_div;
  logic               sa, sb;
  logic [WIDTH-1:0]   ua, ub, quo, rem;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] step_acc;

  assign is_div = op_is_div(op_q);

  multdiv_step #(.WIDTH(WIDTH)) u_step (
    .acc_i    (acc_q),
    .opnd_i   (opnd_q),
    .mbit_i   (mplier_q[0]),
    .is_div_i (is_div),
    .acc_o    (step_acc)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    dz_d     = dz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    divz_d   = divz_q;

    sa   = op_is_signed(op_q) & a_q[WIDTH-1];
    sb   = op_is_signed(op_q) & b_q[WIDTH-1];
    ua   = sa ? -a_q : a_q;
    ub   = sb ? -b_q : b_q;
    quo  = negq_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem  = negr_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    prod = negq_q ? -acc_q : acc_q;

    case (state_q)
      S_IDLE: begin
        if (hilo_we_i[1]) hi_d = wdata_i;
        if (hilo_we_i[0]) lo_d = wdata_i;
        // Operands are captured with the request so the core may move on next cycle.
        if (start_i) begin
          state_d = S_PREP;
          op_d    = op_e'(op_i);
          a_d     = a_i;
          b_d     = b_i;
        end
      end
      S_PREP: begin
        cnt_d  = '0;
        negq_d = sa ^ sb;
        negr_d = sa;
        dz_d   = is_div && (b_q == '0);
        if (is_div) begin
          acc_d    = {{WIDTH{1'b0}}, ua};
          opnd_d   = {{WIDTH{1'b0}}, ub};
          mplier_d = '0;
        end else begin
          acc_d    = '0;
          opnd_d   = {{WIDTH{1'b0}}, ua};
          mplier_d = ub;
        end
        state_d = S_RUN;
      end
      S_RUN: begin
        acc_d = step_acc;
        cnt_d = cnt_q + 1'b1;
        if (!is_div) begin
          opnd_d   = opnd_q << 1;
          mplier_d = mplier_q >> 1;
        end
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
`ifdef MULTDIV_EARLY_OUT_EN
        if (!is_div && (mplier_d == '0)) state_d = S_FIX;
`endif
      end
      S_FIX: begin
        // Results land on the edge into DONE so HI/LO are valid while done is high.
        if (!is_div) begin
          hi_d   = prod[2*WIDTH-1:WIDTH];
          lo_d   = prod[WIDTH-1:0];
          divz_d = 1'b0;
        end else if (dz_q) begin
          hi_d   = a_q;
          lo_d   = '1;
          divz_d = 1'b1;
        end else begin
          hi_d   = rem;
          lo_d   = quo;
          divz_d = 1'b0;
        end
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      op_q     <= OP_MULT;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      divz_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      dz_q     <= dz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      divz_q   <= divz_d;
    end
  end

  assign busy_o     = (state_q != S_IDLE);
  assign done_o     = (state_q == S_DONE);
  assign hi_o       = hi_q;
  assign lo_o       = lo_q;
  assign div_zero_o = divz_q;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Scoreboard bench for multdiv_sequencer: expectations queued at issue, checked at done.
module tb_multdiv_sequencer;

  localparam int W = 32;
`ifdef MULTDIV_EARLY_OUT_EN
  localparam bit EO = 1'b1;
`else
  localparam bit EO = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [1:0]    op;
  logic [W-1:0]  a, b;
  logic [1:0]    hilo_we;
  logic [W-1:0]  wdata;
  logic          busy, done, div_zero;
  logic [W-1:0]  hi, lo;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  multdiv_sequencer dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .op_i       (op),
    .a_i        (a),
    .b_i        (b),
    .hilo_we_i  (hilo_we),
    .wdata_i    (wdata),
    .busy_o     (busy),
    .done_o     (done),
    .hi_o       (hi),
    .lo_o       (lo),
    .div_zero_o (div_zero)
  );

  // Cycle in which done is expected, counting the start cycle as 0.
  function automatic int lat_of(input logic [1:0] o, input logic [W-1:0] y);
    int run;
    logic [W-1:0] mag;
    mag = (o == 2'b00 && y[W-1]) ? -y : y;
    run = 1;
    for (int i = 0; i < W; i++) if (mag[i]) run = i + 1;
    if (EO && !o[1]) return run + 3;
    return W + 3;
  endfunction

  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    longint sx, sy, q, r;
    logic [63:0] t;
    sx = $signed(x);
    sy = $signed(y);
    e.dz = 1'b0;
    t = '0;
    if (o[1] && y == 0) begin
      t = {x, 32'hFFFF_FFFF};
      e.dz = 1'b1;
    end else begin
      case (o)
        2'b00: t = sx * sy;
        2'b01: t = {32'b0, x} * {32'b0, y};
        2'b10: begin q = sx / sy; r = sx % sy; t = {r[31:0], q[31:0]}; end
        default: t = {x % y, x / y};
      endcase
    end
    e.hi  = t[63:32];
    e.lo  = t[31:0];
    e.lat = lat_of(o, y);
    return e;
  endfunction

  function automatic exp_t mk(input logic [W-1:0] h, input logic [W-1:0] l, input logic z, input int lat);
    exp_t e;
    e.hi = h; e.lo = l; e.dz = z; e.lat = lat;
    return e;
  endfunction

  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [1:0] we, input logic [W-1:0] wd, input exp_t e);
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b1; op = o; a = x; b = y; hilo_we = we; wdata = wd;
  endtask

  // Observes one operation: done cycle, busy coverage, and whether HI/LO moved before done.
  task automatic wait_done(input int poke, output int lat, output bit busy_ok, output bit hold_ok,
                           output logic [W-1:0] h1, output logic [W-1:0] l1);
    lat = -1; busy_ok = 1'b1; hold_ok = 1'b1; h1 = '0; l1 = '0;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk); #1;
      if (n == 1) begin start = 1'b0; hilo_we = 2'b00; end
      if (n == 2) begin a = $urandom; b = $urandom; op = 2'($urandom); end
      if (n == poke) begin start = 1'b1; op = 2'b10; hilo_we = 2'b11; wdata = 32'hAAAA_5555; end
      if (n == poke + 1) begin start = 1'b0; hilo_we = 2'b00; end
      @(negedge clk);
      if (n == 1) begin h1 = hi; l1 = lo; end
      if (!busy) busy_ok = 1'b0;
      if (done) begin lat = n; break; end
      if (n > 1 && (hi !== h1 || lo !== l1)) hold_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0; hilo_we = 2'b00; wdata = '0;
    #2;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b exp 0", done); end
    n_cmp++; if (hi !== '0) begin n_bad++; $display("FAIL reset_hi got %h exp 0", hi); end
    n_cmp++; if (lo !== '0) begin n_bad++; $display("FAIL reset_lo got %h exp 0", lo); end
    n_cmp++; if (div_zero !== 1'b0) begin n_bad++; $display("FAIL reset_dz got %b exp 0", div_zero); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_mult_signed();
    int lat; bit bok, hok; logic [W-1:0] h1, l1; exp_t e;
    issue(2'b00, 32'hFFFF_FFFD, 32'd7, 2'b00, '0, mk(32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, lat_of(2'b00, 32'd7)));
    wait_done(0, lat, bok, hok, h1, l1);
    e = sb.pop_front();
    n_cmp++; if (lat !== e.lat) begin n_bad++; $display("FAIL mult_lat got %0d exp %0d", lat, e.lat); end
    n_cmp++; if (bok !== 1'b1) begin n_bad++; $display("FAIL mult_busy_window got %b exp 1", bok); end
    n_cmp++; if (hok !== 1'b1) begin n_bad++; $display("FAIL mult_hilo_hold got %b exp 1", hok); end
    n_cmp++; if (hi !== e.hi) begin n_bad++; $display("FAIL mult_hi got %h exp %h", hi, e.hi); end
    n_cmp++; if (lo !== e.lo) begin n_bad++; $display("FAIL mult_lo got %h exp %h", lo, e.lo); end
    n_cmp++; if (div_zero !== e.dz) begin n_bad++; $display("FAIL mult_dz got %b exp %b", div_zero, e.dz); end
    @(negedge clk);
    n_cmp++; if ({busy, done} !== 2'b00) begin n_bad++; $display("FAIL mult_after_done got %b exp 00", {busy, done}); end
  endtask

  task automatic test_multu_div();
    int lat; bit bok, hok; logic [W-1:0] h1, l1; exp_t e;
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, '0, mk(32'hFFFF_FFFE, 32'h0000_0001, 1'b0, lat_of(2'b01, 32'hFFFF_FFFF)));
    wait_done(0, lat, bok, hok, h1, l1);
    e = sb.pop_front();
    n_cmp++; if (lat !== e.lat) begin n_bad++; $display("FAIL multu_lat got %0d exp %0d", lat, e.lat); end
    n_cmp++; if (hi !== e.hi) begin n_bad++; $display("FAIL multu_hi got %h exp %h", hi, e.hi); end
    n_cmp++; if (lo !== e.lo) begin n_bad++; $display("FAIL multu_lo got %h exp %h", lo, e.lo); end
    issue(2'b10, 32'hFFFF_FFF9, 32'd2, 2'b00, '0, mk(32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, W + 3));
    wait_done(0, lat, bok, hok, h1, l1);
    e = sb.pop_front();
    n_cmp++; if (lat !== e.lat) begin n_bad++; $display("FAIL div_lat got %0d exp %0d", lat, e.lat); end
    n_cmp++; if (bok !== 1'b1) begin n_bad++; $display("FAIL div_busy_window got %b exp 1", bok); end
    n_cmp++; if (hi !== e.hi) begin n_bad++; $display("FAIL div_hi got %h exp %h", hi, e.hi); end
    n_cmp++; if (lo !== e.lo) begin n_bad++; $display("FAIL div_lo got %h exp %h", lo, e.lo); end
    n_cmp++; if (div_zero !== e.dz) begin n_bad++; $display("FAIL div_dz got %b exp %b", div_zero, e.dz); end
  endtask

  task automatic test_div_zero();
    int lat; bit bok, hok; logic [W-1:0] h1, l1; exp_t e;
    issue(2'b11, 32'd7, 32'd0, 2'b00, '0, mk(32'd7, 32'hFFFF_FFFF, 1'b1, W + 3));
    wait_done(0, lat, bok, hok, h1, l1);
    e = sb.pop_front();
    n_cmp++; if (lat !== e.lat) begin n_bad++; $display("FAIL divz_lat got %0d exp %0d", lat, e.lat); end
    n_cmp++; if (hi !== e.hi) begin n_bad++; $display("FAIL divz_hi got %h exp %h", hi, e.hi); end
    n_cmp++; if (lo !== e.lo) begin n_bad++; $display("FAIL divz_lo got %h exp %h", lo, e.lo); end
    n_cmp++; if (div_zero !== e.dz) begin n_bad++; $display("FAIL divz_dz got %b exp %b", div_zero, e.dz); end
    repeat (2) @(negedge clk);
    n_cmp++; if (div_zero !== 1'b1) begin n_bad++; $display("FAIL divz_held got %b exp 1", div_zero); end
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 2'b00, '0, mk(32'h0, 32'h8000_0000, 1'b0, W + 3));
    wait_done(0, lat, bok, hok, h1, l1);
    e = sb.pop_front();
    n_cmp++; if (hi !== e.hi) begin n_bad++; $display("FAIL divovf_hi got %h exp %h", hi, e.hi); end
    n_cmp++; if (lo !== e.lo) begin n_bad++; $display("FAIL divovf_lo got %h exp %h", lo, e.lo); end
    n_cmp++; if (div_zero !== e.dz) begin n_bad++; $display("FAIL divovf_dz got %b exp %b", div_zero, e.dz); end
  endtask

  task automatic test_busy_ignore();
    int lat; bit bok, hok; logic [W-1:0] h1, l1; exp_t e; int extra;
    issue(2'b01, 32'd2, 32'd3, 2'b00, '0, mk(32'h0, 32'd6, 1'b0, lat_of(2'b01, 32'd3)));
    wait_done(10, lat, bok, hok, h1, l1);
    e = sb.pop_front();
    n_cmp++; if (lat !== e.lat) begin n_bad++; $display("FAIL ign_lat got %0d exp %0d", lat, e.lat); end
    n_cmp++; if (hok !== 1'b1) begin n_bad++; $display("FAIL ign_hilo_write_while_busy got %b exp 1", hok); end
    n_cmp++; if (hi !== e.hi) begin n_bad++; $display("FAIL ign_hi got %h exp %h", hi, e.hi); end
    n_cmp++; if (lo !== e.lo) begin n_bad++; $display("FAIL ign_lo got %h exp %h", lo, e.lo); end
    extra = 0;
    repeat (3) begin @(negedge clk); if (busy) extra++; end
    n_cmp++; if (extra !== 0) begin n_bad++; $display("FAIL ign_queued_start got %0d busy cycles exp 0", extra); end
    @(posedge clk); #1 hilo_we = 2'b10; wdata = 32'h0000_1234;
    @(posedge clk); #1 hilo_we = 2'b00;
    @(negedge clk);
    n_cmp++; if (hi !== 32'h0000_1234) begin n_bad++; $display("FAIL mthi_hi got %h exp 00001234", hi); end
    n_cmp++; if (lo !== 32'd6) begin n_bad++; $display("FAIL mthi_lo got %h exp 00000006", lo); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mthi_busy got %b exp 0", busy); end
  endtask

  task automatic test_start_with_write();
    int lat; bit bok, hok; logic [W-1:0] h1, l1; exp_t e;
    issue(2'b01, 32'd1, 32'd1, 2'b01, 32'h0000_5A5A, mk(32'h0, 32'd1, 1'b0, lat_of(2'b01, 32'd1)));
    wait_done(0, lat, bok, hok, h1, l1);
    e = sb.pop_front();
    n_cmp++; if (l1 !== 32'h0000_5A5A) begin n_bad++; $display("FAIL sw_direct_lo got %h exp 00005a5a", l1); end
    n_cmp++; if (h1 !== 32'h0000_1234) begin n_bad++; $display("FAIL sw_direct_hi got %h exp 00001234", h1); end
    n_cmp++; if (lat !== e.lat) begin n_bad++; $display("FAIL sw_lat got %0d exp %0d", lat, e.lat); end
    n_cmp++; if (hi !== e.hi) begin n_bad++; $display("FAIL sw_hi got %h exp %h", hi, e.hi); end
    n_cmp++; if (lo !== e.lo) begin n_bad++; $display("FAIL sw_lo got %h exp %h", lo, e.lo); end
  endtask

  task automatic test_reset_midop();
    int lat; bit bok, hok; logic [W-1:0] h1, l1; exp_t e; int pulses;
    issue(2'b00, 32'd9, 32'd9, 2'b00, '0, mk(32'h0, 32'd81, 1'b0, lat_of(2'b00, 32'd9)));
    @(posedge clk); #1 start = 1'b0;
    repeat (19) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    sb.delete();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy got %b exp 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rstmid_done got %b exp 0", done); end
    n_cmp++; if (hi !== '0) begin n_bad++; $display("FAIL rstmid_hi got %h exp 0", hi); end
    n_cmp++; if (lo !== '0) begin n_bad++; $display("FAIL rstmid_lo got %h exp 0", lo); end
    @(negedge clk) rst = 1'b0;
    pulses = 0;
    repeat (45) begin @(negedge clk); if (done || busy) pulses++; end
    n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL rstmid_discard got %0d active cycles exp 0", pulses); end
    issue(2'b00, 32'd9, 32'd9, 2'b00, '0, mk(32'h0, 32'd81, 1'b0, lat_of(2'b00, 32'd9)));
    wait_done(0, lat, bok, hok, h1, l1);
    e = sb.pop_front();
    n_cmp++; if (lat !== e.lat) begin n_bad++; $display("FAIL rstmid_next_lat got %0d exp %0d", lat, e.lat); end
    n_cmp++; if (hi !== e.hi) begin n_bad++; $display("FAIL rstmid_next_hi got %h exp %h", hi, e.hi); end
    n_cmp++; if (lo !== e.lo) begin n_bad++; $display("FAIL rstmid_next_lo got %h exp %h", lo, e.lo); end
  endtask

  task automatic test_mult_latency();
    int lat; bit bok, hok; logic [W-1:0] h1, l1; exp_t e;
    issue(2'b01, 32'd3, 32'd5, 2'b00, '0, mk(32'h0, 32'd15, 1'b0, EO ? 6 : W + 3));
    wait_done(0, lat, bok, hok, h1, l1);
    e = sb.pop_front();
    n_cmp++; if (lat !== e.lat) begin n_bad++; $display("FAIL lat35_lat got %0d exp %0d", lat, e.lat); end
    n_cmp++; if (lo !== e.lo) begin n_bad++; $display("FAIL lat35_lo got %h exp %h", lo, e.lo); end
    issue(2'b01, 32'd3, 32'd0, 2'b00, '0, mk(32'h0, 32'h0, 1'b0, EO ? 4 : W + 3));
    wait_done(0, lat, bok, hok, h1, l1);
    e = sb.pop_front();
    n_cmp++; if (lat !== e.lat) begin n_bad++; $display("FAIL latb0_lat got %0d exp %0d", lat, e.lat); end
    n_cmp++; if ({hi, lo} !== {e.hi, e.lo}) begin n_bad++; $display("FAIL latb0_hilo got %h exp %h", {hi, lo}, {e.hi, e.lo}); end
  endtask

  task automatic test_random();
    int lat; bit bok, hok; logic [W-1:0] h1, l1; exp_t e;
    logic [1:0] o; logic [W-1:0] x, y;
    for (int i = 0; i < 12; i++) begin
      o = 2'(i % 4);
      x = $urandom;
      y = (i % 3 == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      if (i == 6) y = '0;
      issue(o, x, y, 2'b00, '0, model(o, x, y));
      wait_done(0, lat, bok, hok, h1, l1);
      e = sb.pop_front();
      n_cmp++; if (lat !== e.lat) begin n_bad++; $display("FAIL rnd%0d_lat op=%0d got %0d exp %0d", i, o, lat, e.lat); end
      n_cmp++; if (hi !== e.hi) begin n_bad++; $display("FAIL rnd%0d_hi op=%0d a=%h b=%h got %h exp %h", i, o, x, y, hi, e.hi); end
      n_cmp++; if (lo !== e.lo) begin n_bad++; $display("FAIL rnd%0d_lo op=%0d a=%h b=%h got %h exp %h", i, o, x, y, lo, e.lo); end
      n_cmp++; if (div_zero !== e.dz) begin n_bad++; $display("FAIL rnd%0d_dz op=%0d got %b exp %b", i, o, div_zero, e.dz); end
    end
  endtask

  initial begin
    test_reset();
    test_mult_signed();
    test_multu_div();
    test_div_zero();
    test_busy_ignore();
    test_start_with_write();
    test_reset_midop();
    test_mult_latency();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
